// File: rtl/bin_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero skips the iteration loop and reports all-ones / dividend.
module bin_divider #(
   parameter int unsigned D = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_enable,
   input  logic [D-1:0] i_dba,
   input  logic [D-1:0] i_dbb,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_div_by_zero,
   output logic [D-1:0] o_quotient,
   output logic [D-1:0] o_remainder
);

   localparam int unsigned CW = $clog2(D);
   localparam logic [CW-1:0] LastCnt = CW'(D - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [D-1:0]  r_rem;
   logic [D-1:0]  r_quo;
   logic [D-1:0]  r_div;
   logic [CW-1:0] r_cnt;
   logic [D-1:0]  r_quotient;
   logic [D-1:0]  r_remainder;
   logic          r_dbz;

   logic [D:0]    w_shift;
   logic          w_fits;
   logic [D-1:0]  w_diff;
   logic [D-1:0]  w_rem_next;
   logic [D-1:0]  w_quo_next;
   logic          w_start;
   logic          w_last;

   // Shifted partial remainder is D+1 bits; it is always < 2*divisor.
   assign w_shift    = {r_rem, r_quo[D-1]};
   assign w_fits     = (w_shift >= {1'b0, r_div});
   // When the trial fits the true difference is < divisor, so D bits suffice.
   assign w_diff     = w_shift[D-1:0] - r_div;
   assign w_rem_next = w_fits ? w_diff : w_shift[D-1:0];
   assign w_quo_next = {r_quo[D-2:0], w_fits};

   assign w_start = (r_state == StIdle) && i_enable;
   assign w_last  = (r_state == StRun) && (r_cnt == LastCnt);

   assign o_quotient    = r_quotient;
   assign o_remainder   = r_remainder;
   assign o_div_by_zero = r_dbz;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      w_state_next = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_enable) begin
               w_state_next = (i_dbb == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            o_busy = 1'b1;
            if (r_cnt == LastCnt) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            o_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Working registers: capture operands at start, iterate while running.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rem <= '0;
         r_quo <= '0;
         r_div <= '0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_rem <= '0;
         r_quo <= i_dba;
         r_div <= i_dbb;
         r_cnt <= '0;
      end else if (r_state == StRun) begin
         r_rem <= w_rem_next;
         r_quo <= w_quo_next;
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Result registers: written only on the edge that enters DONE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_start && (i_dbb == '0)) begin
         r_quotient  <= '1;
         r_remainder <= i_dba;
         r_dbz       <= 1'b1;
      end else if (w_last) begin
         r_quotient  <= w_quo_next;
         r_remainder <= w_rem_next;
         r_dbz       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bin_divider.sv
// Self-checking bench for bin_divider: cycle model plus directed literal checks.
module tb_bin_divider;

   localparam int unsigned D = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic [D-1:0] dba = '0;
   logic [D-1:0] dbb = '0;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [D-1:0] quotient;
   logic [D-1:0] remainder;

   int n_checks = 0;
   int n_errors = 0;

   bin_divider #(.D(D)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_dba         (dba),
      .i_dbb         (dbb),
      .o_busy        (busy),
      .o_done        (done),
      .o_div_by_zero (div_by_zero),
      .o_quotient    (quotient),
      .o_remainder   (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Edges after the start edge at which the result appears.
   function automatic int done_t(input logic [D-1:0] b);
      return (b == '0) ? 0 : D;
   endfunction

   // Reference model: operation timeline plus arithmetic results.
   logic         m_active;
   int           m_t;
   logic [D-1:0] m_a, m_b, m_q, m_r;
   logic         m_z;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_t      <= 0;
         m_a      <= '0;
         m_b      <= '0;
         m_q      <= '0;
         m_r      <= '0;
         m_z      <= 1'b0;
      end else if (m_active) begin
         if (m_t == done_t(m_b)) begin
            m_active <= 1'b0;
         end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == done_t(m_b)) begin
               m_q <= m_a / m_b;
               m_r <= m_a % m_b;
               m_z <= 1'b0;
            end
         end
      end else if (enable) begin
         m_active <= 1'b1;
         m_t      <= 0;
         m_a      <= dba;
         m_b      <= dbb;
         if (dbb == '0) begin
            m_q <= '1;
            m_r <= dba;
            m_z <= 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic exp_busy, exp_done;
      exp_busy = m_active && (m_t < done_t(m_b));
      exp_done = m_active && (m_t == done_t(m_b));
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("quotient", 64'(quotient), 64'(m_q));
      check("remainder", 64'(remainder), 64'(m_r));
      check("div_by_zero", 64'(div_by_zero), 64'(m_z));
      if (done && !div_by_zero && m_active) begin
         check("invariant_sum", 64'(quotient) * 64'(m_b) + 64'(remainder), 64'(m_a));
         check("invariant_rem_lt_div", 64'(remainder < m_b), 64'd1);
      end
   end

   // Called at the first falling edge after the start edge.
   task automatic wait_done(output int edges, output int busy_cyc);
      edges = 0;
      busy_cyc = 0;
      while (!done && edges < 40) begin
         busy_cyc += int'(busy);
         @(negedge clk);
         edges++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   task automatic run_op(input logic [D-1:0] a, input logic [D-1:0] b, input bit lit,
                         input logic [D-1:0] eq, input logic [D-1:0] er, input logic ez,
                         input int ebusy);
      int edges, busy_cyc;
      @(negedge clk);
      enable = 1'b1;
      dba = a;
      dbb = b;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      dba = D'($urandom);
      dbb = D'($urandom);
      wait_done(edges, busy_cyc);
      check("edges_to_done", 64'(edges), 64'(done_t(b)));
      if (lit) begin
         check("lit_quotient", 64'(quotient), 64'(eq));
         check("lit_remainder", 64'(remainder), 64'(er));
         check("lit_div_by_zero", 64'(div_by_zero), 64'(ez));
         check("lit_busy_cycles", 64'(busy_cyc), 64'(ebusy));
      end
   endtask

   initial begin
      int edges, busy_cyc, pulses;
      logic [D-1:0] a, b;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_quotient", 64'(quotient), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      // Directed operations with hand-computed results.
      run_op(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 16);
      run_op(16'hFFFF, 16'd1, 1'b1, 16'hFFFF, 16'd0, 1'b0, 16);
      run_op(16'd5, 16'hFFFF, 1'b1, 16'd0, 16'd5, 1'b0, 16);
      run_op(16'd0, 16'd3, 1'b1, 16'd0, 16'd0, 1'b0, 16);
      run_op(16'd1234, 16'd0, 1'b1, 16'hFFFF, 16'd1234, 1'b1, 0);
      run_op(16'd9, 16'd3, 1'b1, 16'd3, 16'd0, 1'b0, 16);

      // Enable held high; operand change during RUN must be ignored.
      @(negedge clk);
      enable = 1'b1;
      dba = 16'd50;
      dbb = 16'd8;
      @(posedge clk);
      @(negedge clk);
      dba = 16'd999;
      wait_done(edges, busy_cyc);
      check("hold_edges", 64'(edges), 64'd16);
      check("hold_quotient", 64'(quotient), 64'd6);
      check("hold_remainder", 64'(remainder), 64'd2);
      @(negedge clk);
      check("hold_done_single", 64'(done), 64'd0);
      check("hold_idle_gap", 64'(busy), 64'd0);
      @(negedge clk);
      check("hold_restart_busy", 64'(busy), 64'd1);
      enable = 1'b0;
      wait_done(edges, busy_cyc);
      check("restart_quotient", 64'(quotient), 64'd124);
      check("restart_remainder", 64'(remainder), 64'd7);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      enable = 1'b1;
      dba = 16'd1000;
      dbb = 16'd3;
      @(negedge clk);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_busy", 64'(busy), 64'd0);
      check("async_done", 64'(done), 64'd0);
      check("async_quotient", 64'(quotient), 64'd0);
      check("async_remainder", 64'(remainder), 64'd0);
      check("async_div_by_zero", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         pulses += int'(done);
      end
      check("abort_no_done", 64'(pulses), 64'd0);

      // Random operands, including zero and extreme divisors.
      for (int i = 0; i < 2000; i++) begin
         a = D'($urandom);
         if ($urandom_range(0, 15) == 0) a = '0;
         case ($urandom_range(0, 9))
            0: b = '0;
            1: b = D'($urandom_range(1, 15));
            2: b = '1;
            default: b = D'($urandom);
         endcase
         run_op(a, b, 1'b0, '0, '0, 1'b0, 0);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
